pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline. Works alongside the
//  forwarding unit: forwarding resolves ALU RAW hazards; this block covers what
//  forwarding cannot (load-use, I/D cache wait, taken-branch squash, halt drain).
//  Drives every pipeline-latch enable/flush and PC enable, and keeps saturating
//  performance counters.
// PARAMETERS
//  CNT_W   16  width of each saturating performance counter
// PORTS
//  CLK              in   1      system clock, rising edge
//  nRST             in   1      asynchronous, active-low reset
//  id_rs            in   5      ID-stage source reg rs
//  id_rt            in   5      ID-stage source reg rt
//  id_uses_rt       in   1      ID instr reads rt (R-type/store/branch)
//  ex_memRead       in   1      EX instr is a load
//  ex_dest          in   5      EX instr destination reg
//  ex_branch_taken  in   1      branch/jump resolved taken in EX
//  mem_dmemREN      in   1      MEM stage data read request
//  mem_dmemWEN      in   1      MEM stage data write request
//  dhit             in   1      data cache hit/complete
//  ihit             in   1      instruction fetch complete
//  wb_halt          in   1      HALT instr in WB
//  pc_en            out  1      PC update enable
//  ifid_en          out  1      IF/ID latch enable
//  ifid_flush       out  1      IF/ID loads NOP (when enabled)
//  idex_en          out  1      ID/EX latch enable
//  idex_flush       out  1      ID/EX loads NOP (when enabled)
//  exmem_en         out  1      EX/MEM latch enable
//  memwb_en         out  1      MEM/WB latch enable
//  halt             out  1      sticky halt to system
//  dbg_state        out  2      FSM state: 00 RUN, 01 DWAIT, 10 HALT
//  stall_cycles     out  CNT_W  cycles with pc_en=0 outside HALT
//  flush_events     out  CNT_W  taken-branch squashes applied
//  lu_events        out  CNT_W  load-use bubbles inserted
// BEHAVIOUR
//  Reset (async, nRST=0): state=RUN, halt=0, all counters 0; outputs follow the
//    comb decode immediately.
//  Conditions (comb):
//    memwait = (mem_dmemREN|mem_dmemWEN) & ~dhit
//    loaduse = ex_memRead & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt))
//  Output decode, strict priority, zero latency (same cycle as inputs):
//    1 state==HALT or wb_halt: all enables 0, all flushes 0.
//    2 memwait: all enables 0 (full freeze, EX branch held for later).
//    3 ex_branch_taken: all en=1, ifid_flush=1, idex_flush=1 (pc loads target;
//      squashes load-use/ifetch-wait in the same cycle).
//    4 loaduse: pc_en=0, ifid_en=0, idex_en=1+idex_flush=1, exmem_en=memwb_en=1.
//      Exactly one bubble: next cycle EX holds the NOP, so loaduse clears.
//    5 ~ihit: pc_en=0, ifid_en=1+ifid_flush=1, rest en=1.
//    6 else: all en=1, flushes 0.
//  FSM (registered, rising CLK):
//    RUN  -> HALT on wb_halt; -> DWAIT on memwait; else RUN.
//    DWAIT-> HALT on wb_halt; -> RUN when ~memwait (dhit or request dropped).
//    HALT -> HALT until reset (sticky); halt=1 from the cycle after entry.
//  Counters (registered, saturate at all-ones, never wrap; frozen in HALT):
//    stall_cycles += (pc_en==0) & state!=HALT & ~wb_halt
//    flush_events += decode case 3 taken; lu_events += decode case 4 taken.
//  Simultaneous: dhit and ihit same cycle -> case 6 (all advance).
//    memwait + branch -> freeze; branch squash applies in the dhit cycle.
//  Reset mid-DWAIT/HALT -> RUN, counters cleared, no residual freeze.
// TESTING
//  lw r2 in EX, ID add r3,r2,r1, ihit=dhit=1 -> 1 cycle: pc_en=0,ifid_en=0,idex_flush=1; lu_events=1.
//  Same load, ID uses r0 or rt-only with id_uses_rt=0 -> no stall, all en=1.
//  mem_dmemREN=1, dhit low 3 cycles -> all en=0 3 cycles, dbg_state=01, stall_cycles=3; dhit -> RUN.
//  ex_branch_taken=1 with loaduse and ihit=0 -> ifid_flush=idex_flush=1, pc_en=1, flush_events=1, lu_events=0.
//  wb_halt=1 -> all en=0 that cycle; halt=1, dbg_state=10 next; stays after inputs clear; nRST low -> halt=0.
//  Force stall 2^CNT_W+5 cycles -> stall_cycles holds 0xFFFF (no wrap).

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, cache waits,
// taken-branch squash and halt drain, plus saturating performance counters.
module pipeline_hazard_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_dest,
    input  logic             ex_branch_taken,
    input  logic             mem_dmemREN,
    input  logic             mem_dmemWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halt,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] lu_events
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DWAIT = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    logic memwait;
    logic loaduse;
    logic rs_hit;
    logic rt_hit;
    logic in_halt;

    logic sel_halt;
    logic sel_mem;
    logic sel_br;
    logic sel_lu;
    logic sel_if;
    logic sel_run;

    logic stall_inc;
    logic flush_inc;
    logic lu_inc;

    assign in_halt = (state == HALT);
    assign memwait = (mem_dmemREN | mem_dmemWEN) & ~dhit;
    assign rs_hit  = (ex_dest == id_rs);
    assign rt_hit  = id_uses_rt & (ex_dest == id_rt);
    assign loaduse = ex_memRead & (ex_dest != 5'd0) & (rs_hit | rt_hit);

    // Priority chain flattened into one-hot selects
    assign sel_halt = in_halt | wb_halt;
    assign sel_mem  = ~sel_halt & memwait;
    assign sel_br   = ~sel_halt & ~memwait & ex_branch_taken;
    assign sel_lu   = ~sel_halt & ~memwait & ~ex_branch_taken & loaduse;
    assign sel_if   = ~sel_halt & ~memwait & ~ex_branch_taken & ~loaduse
                    & ~ihit;
    assign sel_run  = ~sel_halt & ~memwait & ~ex_branch_taken & ~loaduse
                    & ihit;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        unique case (1'b1)
            sel_halt, sel_mem: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            sel_br: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            sel_lu: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            sel_if: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            sel_run: begin
                pc_en = 1'b1;
            end
            default: begin
                pc_en = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (wb_halt) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end else if (memwait) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (wb_halt) begin
                        state <= HALT;
                        halt  <= 1'b1;
                    end else if (!memwait) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    // Counters freeze once halted; wb_halt cycle is a drain, not a stall
    assign stall_inc = ~pc_en & ~in_halt & ~wb_halt;
    assign flush_inc = sel_br;
    assign lu_inc    = sel_lu;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_events <= '0;
            lu_events    <= '0;
        end else begin
            if (stall_inc && stall_cycles != '1)
                stall_cycles <= stall_cycles + ONE;
            if (flush_inc && flush_events != '1)
                flush_events <= flush_events + ONE;
            if (lu_inc && lu_events != '1)
                lu_events <= lu_events + ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: decode table plus
// multi-cycle sequences for load-use, dcache wait, squash, halt, saturation.
module tb_pipeline_hazard_controller;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_memRead;
    logic [4:0]  ex_dest;
    logic        ex_branch_taken;
    logic        mem_dmemREN;
    logic        mem_dmemWEN;
    logic        dhit;
    logic        ihit;
    logic        wb_halt;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        memwb_en;
    logic        halt;
    logic [1:0]  dbg_state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
    logic [15:0] lu_events;

    int n_vec = 0;
    int n_err = 0;

    pipeline_hazard_controller #(.CNT_W(16)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memRead      (ex_memRead),
        .ex_dest         (ex_dest),
        .ex_branch_taken (ex_branch_taken),
        .mem_dmemREN     (mem_dmemREN),
        .mem_dmemWEN     (mem_dmemWEN),
        .dhit            (dhit),
        .ihit            (ihit),
        .wb_halt         (wb_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .halt            (halt),
        .dbg_state       (dbg_state),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .lu_events       (lu_events)
    );

    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] E_RUN  = 7'b1101011;
    localparam logic [6:0] E_FRZ  = 7'b0000000;
    localparam logic [6:0] E_BR   = 7'b1111111;
    localparam logic [6:0] E_LU   = 7'b0001111;
    localparam logic [6:0] E_IF   = 7'b0111011;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] dest;
        logic       br;
        logic       ren;
        logic       wen;
        logic       dh;
        logic       ih;
        logic [6:0] exp_en;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [6:0] en_vec();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, memwb_en};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memRead = 1'b0; ex_dest = 5'd0; ex_branch_taken = 1'b0;
        mem_dmemREN = 1'b0; mem_dmemWEN = 1'b0;
        dhit = 1'b1; ihit = 1'b1; wb_halt = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        #3;
        nRST = 1'b1;
        step();
    endtask

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        ex_memRead = v.mem_read; ex_dest = v.dest;
        ex_branch_taken = v.br;
        mem_dmemREN = v.ren; mem_dmemWEN = v.wen;
        dhit = v.dh; ihit = v.ih; wb_halt = 1'b0;
    endtask

    initial begin
        //          name        rs  rt  ut mr dst br rn wn dh ih exp
        vecs[0]  = '{"idle",     1,  2, 1, 0, 0, 0, 0, 0, 1, 1, E_RUN};
        vecs[1]  = '{"lu_rs",    2,  1, 1, 1, 2, 0, 0, 0, 1, 1, E_LU};
        vecs[2]  = '{"lu_rt",    5,  2, 1, 1, 2, 0, 0, 0, 1, 1, E_LU};
        vecs[3]  = '{"rt_nouse", 5,  2, 0, 1, 2, 0, 0, 0, 1, 1, E_RUN};
        vecs[4]  = '{"r0_dest",  0,  0, 1, 1, 0, 0, 0, 0, 1, 1, E_RUN};
        vecs[5]  = '{"no_load",  2,  2, 1, 0, 2, 0, 0, 0, 1, 1, E_RUN};
        vecs[6]  = '{"imiss",    1,  2, 1, 0, 0, 0, 0, 0, 1, 0, E_IF};
        vecs[7]  = '{"dwait_rd", 1,  2, 1, 0, 0, 0, 1, 0, 0, 1, E_FRZ};
        vecs[8]  = '{"dwait_wr", 1,  2, 1, 0, 0, 0, 0, 1, 0, 1, E_FRZ};
        vecs[9]  = '{"dhit_rd",  1,  2, 1, 0, 0, 0, 1, 0, 1, 1, E_RUN};
        vecs[10] = '{"branch",   1,  2, 1, 0, 0, 1, 0, 0, 1, 1, E_BR};
        vecs[11] = '{"br_lu_if", 2,  1, 1, 1, 2, 1, 0, 0, 1, 0, E_BR};
        vecs[12] = '{"br_dwait", 1,  2, 1, 0, 0, 1, 1, 0, 0, 1, E_FRZ};
        vecs[13] = '{"lu_imiss", 2,  1, 1, 1, 2, 0, 0, 0, 1, 0, E_LU};
        vecs[14] = '{"both_hit", 1,  2, 1, 0, 0, 0, 1, 1, 1, 1, E_RUN};
        vecs[15] = '{"noreq_dh0",1,  2, 1, 0, 0, 0, 0, 0, 0, 1, E_RUN};

        do_reset();
        mid();
        check("rst_en", 32'(en_vec()), 32'(E_RUN));
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_flush", 32'(flush_events), 32'd0);
        check("rst_lu", 32'(lu_events), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step();
            apply(vecs[i]);
            mid();
            check(vecs[i].name, 32'(en_vec()), 32'(vecs[i].exp_en));
        end

        // Load-use: exactly one bubble, EX then holds the NOP
        do_reset();
        apply(vecs[1]);
        mid();
        check("lu_seq_en", 32'(en_vec()), 32'(E_LU));
        step();
        ex_memRead = 1'b0;
        ex_dest = 5'd0;
        mid();
        check("lu_seq_next", 32'(en_vec()), 32'(E_RUN));
        check("lu_seq_cnt", 32'(lu_events), 32'd1);
        check("lu_seq_stall", 32'(stall_cycles), 32'd1);

        // Data cache wait for three cycles
        do_reset();
        mem_dmemREN = 1'b1;
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("dw_frz", 32'(en_vec()), 32'(E_FRZ));
            step();
            check("dw_state", 32'(dbg_state), 32'd1);
        end
        dhit = 1'b1;
        mid();
        check("dw_hit_en", 32'(en_vec()), 32'(E_RUN));
        check("dw_stall", 32'(stall_cycles), 32'd3);
        step();
        check("dw_back_run", 32'(dbg_state), 32'd0);
        check("dw_stall_hold", 32'(stall_cycles), 32'd3);

        // Branch squashes load-use and ifetch wait
        do_reset();
        apply(vecs[11]);
        mid();
        check("br_combo_en", 32'(en_vec()), 32'(E_BR));
        step();
        idle();
        check("br_flush_cnt", 32'(flush_events), 32'd1);
        check("br_lu_cnt", 32'(lu_events), 32'd0);
        check("br_stall_cnt", 32'(stall_cycles), 32'd0);

        // Branch held by dcache wait, squash lands in the dhit cycle
        do_reset();
        apply(vecs[12]);
        mid();
        check("brw_frz", 32'(en_vec()), 32'(E_FRZ));
        step();
        check("brw_noflush", 32'(flush_events), 32'd0);
        dhit = 1'b1;
        mid();
        check("brw_squash", 32'(en_vec()), 32'(E_BR));
        step();
        idle();
        check("brw_flush", 32'(flush_events), 32'd1);

        // Halt: drain cycle, sticky afterwards, cleared by reset
        do_reset();
        wb_halt = 1'b1;
        mid();
        check("halt_en", 32'(en_vec()), 32'(E_FRZ));
        check("halt_not_yet", 32'(halt), 32'd0);
        step();
        idle();
        check("halt_set", 32'(halt), 32'd1);
        check("halt_state", 32'(dbg_state), 32'd2);
        ex_branch_taken = 1'b1;
        repeat (3) step();
        mid();
        check("halt_sticky", 32'(halt), 32'd1);
        check("halt_en_hold", 32'(en_vec()), 32'(E_FRZ));
        check("halt_stall0", 32'(stall_cycles), 32'd0);
        check("halt_flush0", 32'(flush_events), 32'd0);
        idle();
        #1;
        nRST = 1'b0;
        #1;
        check("halt_rst", 32'(halt), 32'd0);
        check("halt_rst_st", 32'(dbg_state), 32'd0);
        check("halt_rst_en", 32'(en_vec()), 32'(E_RUN));
        nRST = 1'b1;

        // Reset in the middle of a dcache wait
        step();
        mem_dmemREN = 1'b1;
        dhit = 1'b0;
        repeat (2) step();
        idle();
        nRST = 1'b0;
        #1;
        check("dw_rst_st", 32'(dbg_state), 32'd0);
        check("dw_rst_cnt", 32'(stall_cycles), 32'd0);
        check("dw_rst_en", 32'(en_vec()), 32'(E_RUN));
        nRST = 1'b1;

        // Saturation: 2^16+5 stalled cycles
        step();
        mem_dmemREN = 1'b1;
        dhit = 1'b0;
        repeat (65541) step();
        check("sat_stall", 32'(stall_cycles), 32'h0000FFFF);
        check("sat_state", 32'(dbg_state), 32'd1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
